sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-requester arbiter and sequencer for the 64x64-bit `sram_extension` single-port memory. It accepts read/write requests from two independent masters over a valid/ready handshake and grants at most one per cycle, round-robin by default. It drives the memory's address, data, write-enable and output-enable pins from registers, and returns read data to the issuing requester with a fixed latency. It sits between the memory and its two clients, which are a DMA-style loader and a compute engine.

## Interface
- BW_DATA, 64, data width; must equal the memory width.
- BW_ADDR, 6, address width; must equal the memory address width.
- i_clk  in  1  single clock; everything is on the rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_req_val  in  2  request valid, one bit per requester (bit n = requester n).
- o_req_rdy  out  2  request ready; one-hot or zero.
- i_req_wr  in  2  per requester: 1 = write, 0 = read.
- i_req_addr  in  2*BW_ADDR  per-requester address; requester n uses slice [n*BW_ADDR +: BW_ADDR].
- i_req_data  in  2*BW_DATA  per-requester write data.
- o_rsp_val  out  2  read-response valid, one-hot or zero.
- o_rsp_data  out  BW_DATA  read data, shared by both requesters; qualified by o_rsp_val.
- o_mem_addr  out  BW_ADDR  to the memory's i_addr.
- o_mem_data  out  BW_DATA  to the memory's i_data.
- o_mem_wen  out  1  to the memory's i_wen; 1 = write this cycle.
- o_mem_oen  out  1  to the memory's i_oen; 1 = read this cycle.
- i_mem_data  in  BW_DATA  from the memory's o_data.

## Operation
- **Handshake.** A request transfers in the cycle where i_req_val[n] and o_req_rdy[n] are both 1.
  - o_req_rdy is combinational from i_req_val and the priority state.
  - At most one bit of o_req_rdy is set per cycle.
  - No bit is set while i_rst is high.
- **Grant rule.**
  - Only one requester valid: it is granted.
  - Both valid: the requester that was not granted most recently wins.
  - The last-grant pointer updates only on an actual transfer.
  - After reset the pointer points at requester 1, so requester 0 wins the first tie.
- **Issue stage.** On a transfer, the following are registered for the next cycle (the access cycle):
  - o_mem_addr = requester's address.
  - o_mem_data = requester's data.
  - o_mem_wen = i_req_wr.
  - o_mem_oen = ~i_req_wr.
  - A tag (requester id, is-read) is registered alongside.
- **Idle cycles.** With no transfer, the next cycle has o_mem_wen = 0 and o_mem_oen = 0. o_mem_addr and o_mem_data hold their previous values.
- **Response pipe.** The tag is shifted two stages, matching the memory's one-cycle registered read.
  - When the tag reaches the end with is-read = 1, i_mem_data is registered into o_rsp_data.
  - In the same cycle, o_rsp_val[id] = 1.
- **Writes.** Writes produce no response.
- **Back-pressure.** Responses cannot be back-pressured; requesters must sink o_rsp_val unconditionally.
- **Ordering.** Read-after-write to the same address, in consecutive accepted requests, returns the new data, because accesses reach the memory strictly in accept order.
- **Reset.** Reset asserted mid-operation discards all in-flight tags. No o_rsp_val is produced for requests accepted before reset.

## Timing
- **Reset values:**
  - o_req_rdy = 0, o_rsp_val = 0.
  - o_rsp_data = 0, o_mem_addr = 0, o_mem_data = 0.
  - o_mem_wen = 0, o_mem_oen = 0.
  - Pointer = requester 1.
- **Latency.** With a transfer in cycle T:
  - The memory access is in cycle T+1.
  - Memory read data is valid in T+2.
  - o_rsp_val and o_rsp_data are valid in T+3.
- **Throughput.** One access per cycle, sustained.
  - With both requesters continuously valid, grants alternate 0,1,0,1…
  - Each requester gets exactly 50% of cycles.
- **Simultaneous events.** A new grant, an in-flight access and a response may all occur in the same cycle; no stall is ever inserted.

## Configuration
- Macro: SRAM_ARBITER_RR_EN.
- Defined: the round-robin tie-break described above.
- Undefined: fixed priority, where requester 0 always wins ties and the pointer logic is removed. Everything else is unchanged (latency, response pipe, reset values).

## Structure
- **Shared package sram_arbiter_pkg:**
  - Localparams N_REQ = 2 and MEM_RD_LAT = 1.
  - The tag typedef {valid, is_read, id}.
- **Sub-module sram_arbiter_grant:**
  - Purely combinational: i_val[1:0] plus pointer gives a one-hot grant.
  - Contains the SRAM_ARBITER_RR_EN branch.
  - The top level holds the issue registers and the response pipe.

## Test plan
- Reset, then requester 0 writes 0x0123_4567_89AB_CDEF to address 5 and then reads address 5. Expected:
  - o_mem_wen = 1 in T+1 for the write.
  - o_rsp_val = 2'b01 with data 0x0123_4567_89AB_CDEF three cycles after the read is accepted.
- Both requesters hold valid reads (requester 0 at address 1, requester 1 at address 2) for 8 cycles. Expected:
  - o_req_rdy sequence 01,10,01,10…
  - Responses alternate with the correct data.
  - The same stimulus with SRAM_ARBITER_RR_EN undefined gives o_req_rdy = 01 on every cycle.
- Back-to-back write to address 0x3F followed by read of 0x3F from different requesters → the read returns the newly written value (wrap-top address).
- An idle gap with no valid requests → o_mem_wen = 0 and o_mem_oen = 0, with o_mem_addr held.
- Accept a read, then assert i_rst in T+1 → no o_rsp_val in T+3, and all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_arbiter_pkg
// Shared definitions for the two-requester SRAM arbiter:
//   N_REQ       number of requesters
//   MEM_RD_LAT  registered read latency of the attached memory (cycles)
//   tag_t       per-access tag carried down the response pipe
//   id_to_onehot helper turning a requester id into a response-valid vector
// -----------------------------------------------------------------------------
package sram_arbiter_pkg;

  localparam int N_REQ      = 2;
  localparam int MEM_RD_LAT = 1;

  typedef struct packed {
    logic valid;
    logic is_read;
    logic id;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, is_read: 1'b0, id: 1'b0};

  function automatic logic [N_REQ-1:0] id_to_onehot(input logic id);
    logic [N_REQ-1:0] oh;
    if (id) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/sram_arbiter_grant.sv
// -----------------------------------------------------------------------------
// sram_arbiter_grant
// Purely combinational grant selection for two requesters.
// Configuration macro: SRAM_ARBITER_RR_EN
//   defined   : round-robin tie-break using the last-grant pointer
//   undefined : fixed priority, requester 0 wins every tie (no pointer port)
// Ports:
//   i_val   request-valid vector, bit n = requester n
//   i_last  (RR only) id of the most recently granted requester
//   o_gnt   one-hot grant, zero when nothing is valid
// -----------------------------------------------------------------------------
module sram_arbiter_grant
  import sram_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] i_val,
`ifdef SRAM_ARBITER_RR_EN
  input  logic             i_last,
`endif
  output logic [N_REQ-1:0] o_gnt
);

  // Select a single winner from the valid requesters
  always_comb begin
    o_gnt = 2'b00;
    case (i_val)
      2'b01: o_gnt = 2'b01;
      2'b10: o_gnt = 2'b10;
      2'b11: begin
`ifdef SRAM_ARBITER_RR_EN
        // The requester not granted most recently wins the tie
        if (i_last) begin
          o_gnt = 2'b01;
        end else begin
          o_gnt = 2'b10;
        end
`else
        o_gnt = 2'b01;
`endif
      end
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Two-requester arbiter and sequencer for a 64x64-bit single-port SRAM with a
// one-cycle registered read. Accepts one request per cycle, drives the memory
// pins from registers and returns read data three cycles after acceptance.
// Configuration macro: SRAM_ARBITER_RR_EN (round-robin ties; fixed priority
// to requester 0 when undefined).
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_req_val/o_req_rdy       per-requester valid/ready handshake
//   i_req_wr                  per-requester 1 = write, 0 = read
//   i_req_addr, i_req_data    per-requester address / write data (packed)
//   o_rsp_val, o_rsp_data     one-hot read-response valid, shared read data
//   o_mem_addr/data/wen/oen   registered memory pins
//   i_mem_data                memory read data
// -----------------------------------------------------------------------------
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int BW_DATA = 64,
  parameter int BW_ADDR = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req_val,
  output logic [N_REQ-1:0]         o_req_rdy,
  input  logic [N_REQ-1:0]         i_req_wr,
  input  logic [N_REQ*BW_ADDR-1:0] i_req_addr,
  input  logic [N_REQ*BW_DATA-1:0] i_req_data,
  output logic [N_REQ-1:0]         o_rsp_val,
  output logic [BW_DATA-1:0]       o_rsp_data,
  output logic [BW_ADDR-1:0]       o_mem_addr,
  output logic [BW_DATA-1:0]       o_mem_data,
  output logic                     o_mem_wen,
  output logic                     o_mem_oen,
  input  logic [BW_DATA-1:0]       i_mem_data
);

  logic [N_REQ-1:0]   gnt_s;
  logic [N_REQ-1:0]   rdy_s;
  logic               xfer_s;
  logic               gnt_id_s;
  logic [BW_ADDR-1:0] sel_addr_s;
  logic [BW_DATA-1:0] sel_data_s;
  logic               sel_wr_s;
  tag_t               new_tag_s;

  logic [BW_ADDR-1:0] mem_addr_r;
  logic [BW_DATA-1:0] mem_data_r;
  logic               mem_wen_r;
  logic               mem_oen_r;
  tag_t               tag_pipe_r [0:MEM_RD_LAT];
  logic [N_REQ-1:0]   rsp_val_r;
  logic [BW_DATA-1:0] rsp_data_r;

`ifdef SRAM_ARBITER_RR_EN
  logic               last_r;

  sram_arbiter_grant u_grant (
    .i_val  (i_req_val),
    .i_last (last_r),
    .o_gnt  (gnt_s)
  );

  // Last-grant pointer; moves only on an actual transfer, resets to requester 1
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_r <= 1'b1;
    end else if (xfer_s) begin
      last_r <= gnt_id_s;
    end else begin
      last_r <= last_r;
    end
  end
`else
  sram_arbiter_grant u_grant (
    .i_val  (i_req_val),
    .o_gnt  (gnt_s)
  );
`endif

  // Ready is the grant, suppressed while reset is asserted
  always_comb begin
    if (i_rst) begin
      rdy_s = 2'b00;
    end else begin
      rdy_s = gnt_s;
    end
  end

  // Mux the granted requester's fields and build its tag
  always_comb begin
    xfer_s   = |rdy_s;
    gnt_id_s = rdy_s[1];
    if (gnt_id_s) begin
      sel_addr_s = i_req_addr[BW_ADDR +: BW_ADDR];
      sel_data_s = i_req_data[BW_DATA +: BW_DATA];
      sel_wr_s   = i_req_wr[1];
    end else begin
      sel_addr_s = i_req_addr[0 +: BW_ADDR];
      sel_data_s = i_req_data[0 +: BW_DATA];
      sel_wr_s   = i_req_wr[0];
    end
    new_tag_s         = TAG_IDLE;
    new_tag_s.valid   = xfer_s;
    new_tag_s.is_read = xfer_s & ~sel_wr_s;
    new_tag_s.id      = gnt_id_s;
  end

  // Issue stage: memory pins for the access cycle; address/data hold when idle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_addr_r <= {BW_ADDR{1'b0}};
      mem_data_r <= {BW_DATA{1'b0}};
      mem_wen_r  <= 1'b0;
      mem_oen_r  <= 1'b0;
    end else if (xfer_s) begin
      mem_addr_r <= sel_addr_s;
      mem_data_r <= sel_data_s;
      mem_wen_r  <= sel_wr_s;
      mem_oen_r  <= ~sel_wr_s;
    end else begin
      mem_addr_r <= mem_addr_r;
      mem_data_r <= mem_data_r;
      mem_wen_r  <= 1'b0;
      mem_oen_r  <= 1'b0;
    end
  end

  // Tag pipe: stage 0 is the access cycle, the last stage sees memory read data
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i <= MEM_RD_LAT; i++) begin
        tag_pipe_r[i] <= TAG_IDLE;
      end
    end else begin
      tag_pipe_r[0] <= new_tag_s;
      for (int i = 1; i <= MEM_RD_LAT; i++) begin
        tag_pipe_r[i] <= tag_pipe_r[i-1];
      end
    end
  end

  // Response register: capture read data when a read tag reaches the end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_val_r  <= 2'b00;
      rsp_data_r <= {BW_DATA{1'b0}};
    end else if (tag_pipe_r[MEM_RD_LAT].valid && tag_pipe_r[MEM_RD_LAT].is_read) begin
      rsp_val_r  <= id_to_onehot(tag_pipe_r[MEM_RD_LAT].id);
      rsp_data_r <= i_mem_data;
    end else begin
      rsp_val_r  <= 2'b00;
      rsp_data_r <= rsp_data_r;
    end
  end

  assign o_req_rdy  = rdy_s;
  assign o_mem_addr = mem_addr_r;
  assign o_mem_data = mem_data_r;
  assign o_mem_wen  = mem_wen_r;
  assign o_mem_oen  = mem_oen_r;
  assign o_rsp_val  = rsp_val_r;
  assign o_rsp_data = rsp_data_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Directed self-checking bench for sram_arbiter with a behavioural model of
// the 64x64 single-port memory (one-cycle registered read). Expected grant
// patterns follow SRAM_ARBITER_RR_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int BW_DATA = 64;
  localparam int BW_ADDR = 6;

  localparam logic [63:0] D_T1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D_A1 = 64'hA1A1_0000_1111_0001;
  localparam logic [63:0] D_A2 = 64'hB2B2_2222_3333_0002;
  localparam logic [63:0] D_W  = 64'hFEED_FACE_DEAD_BEEF;

`ifdef SRAM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [1:0]               req_val;
  logic [1:0]               req_rdy;
  logic [1:0]               req_wr;
  logic [2*BW_ADDR-1:0]     req_addr;
  logic [2*BW_DATA-1:0]     req_data;
  logic [1:0]               rsp_val;
  logic [BW_DATA-1:0]       rsp_data;
  logic [BW_ADDR-1:0]       mem_addr;
  logic [BW_DATA-1:0]       mem_wdata;
  logic                     mem_wen;
  logic                     mem_oen;
  logic [BW_DATA-1:0]       mem_q;

  logic [BW_DATA-1:0]       mem [0:63];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Memory model: synchronous write, registered read
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    if (mem_oen) mem_q <= mem[mem_addr];
  end

  sram_arbiter #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_val  (req_val),
    .o_req_rdy  (req_rdy),
    .i_req_wr   (req_wr),
    .i_req_addr (req_addr),
    .i_req_data (req_data),
    .o_rsp_val  (rsp_val),
    .o_rsp_data (rsp_data),
    .o_mem_addr (mem_addr),
    .o_mem_data (mem_wdata),
    .o_mem_wen  (mem_wen),
    .o_mem_oen  (mem_oen),
    .i_mem_data (mem_q)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_val = 2'b00;
    req_wr  = 2'b00;
  endtask

  task automatic set_req(input int id, input logic wr, input logic [5:0] addr, input logic [63:0] data);
    req_val[id] = 1'b1;
    req_wr[id]  = wr;
    req_addr[id*BW_ADDR +: BW_ADDR] = addr;
    req_data[id*BW_DATA +: BW_DATA] = data;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_rdy"},      req_rdy,   64'h0);
    check_eq({pfx, "_rsp_val"},  rsp_val,   64'h0);
    check_eq({pfx, "_rsp_data"}, rsp_data,  64'h0);
    check_eq({pfx, "_mem_addr"}, mem_addr,  64'h0);
    check_eq({pfx, "_mem_data"}, mem_wdata, 64'h0);
    check_eq({pfx, "_mem_wen"},  mem_wen,   64'h0);
    check_eq({pfx, "_mem_oen"},  mem_oen,   64'h0);
  endtask

  initial begin
    logic [1:0]  exp_rdy;
    logic [1:0]  exp_val;
    logic [63:0] exp_data;
    int          gid;

    // ---------------- reset, with both requesters valid ----------------
    rst      = 1'b1;
    req_addr = '0;
    req_data = '0;
    clear_req();
    req_val  = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;
    check_eq("ptr_reset_tie", req_rdy, 64'h1);
    clear_req();
    step();

    // ---------------- write then read address 5 ----------------
    set_req(0, 1'b1, 6'd5, D_T1);
    #1;
    check_eq("t1_wr_rdy", req_rdy, 64'h1);
    step();
    clear_req();
    set_req(0, 1'b0, 6'd5, 64'h0);
    #1;
    check_eq("t1_wr_wen",  mem_wen,   64'h1);
    check_eq("t1_wr_oen",  mem_oen,   64'h0);
    check_eq("t1_wr_addr", mem_addr,  64'h5);
    check_eq("t1_wr_data", mem_wdata, D_T1);
    check_eq("t1_rd_rdy",  req_rdy,   64'h1);
    step();
    clear_req();
    check_eq("t1_rd_oen",  mem_oen,  64'h1);
    check_eq("t1_rd_wen",  mem_wen,  64'h0);
    check_eq("t1_rd_addr", mem_addr, 64'h5);
    step();
    check_eq("t1_rsp_early", rsp_val, 64'h0);
    step();
    check_eq("t1_rsp_val",  rsp_val,  64'h1);
    check_eq("t1_rsp_data", rsp_data, D_T1);
    step();
    check_eq("t1_rsp_pulse", rsp_val, 64'h0);

    // ---------------- contention: preload, then both read ----------------
    set_req(0, 1'b1, 6'd1, D_A1);
    step();
    clear_req();
    set_req(1, 1'b1, 6'd2, D_A2);
    step();
    clear_req();
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        set_req(0, 1'b0, 6'd1, 64'h0);
        set_req(1, 1'b0, 6'd2, 64'h0);
      end else begin
        clear_req();
      end
      #1;
      if (c >= 8)              exp_rdy = 2'b00;
      else if (RR && (c % 2))  exp_rdy = 2'b10;
      else                     exp_rdy = 2'b01;
      check_eq($sformatf("rr_rdy_c%0d", c), req_rdy, {62'h0, exp_rdy});
      if (c >= 3 && c < 11) begin
        gid      = RR ? ((c - 3) % 2) : 0;
        exp_val  = (gid == 1) ? 2'b10 : 2'b01;
        exp_data = (gid == 1) ? D_A2 : D_A1;
        check_eq($sformatf("rr_rsp_val_c%0d", c), rsp_val, {62'h0, exp_val});
        check_eq($sformatf("rr_rsp_data_c%0d", c), rsp_data, exp_data);
      end else begin
        check_eq($sformatf("rr_rsp_none_c%0d", c), rsp_val, 64'h0);
      end
      step();
    end
    clear_req();

    // ---------------- wrap-top write then read from other requester ----------------
    set_req(1, 1'b1, 6'h3F, D_W);
    #1;
    check_eq("wrap_wr_rdy", req_rdy, 64'h2);
    step();
    clear_req();
    set_req(0, 1'b0, 6'h3F, 64'h0);
    #1;
    check_eq("wrap_rd_rdy",  req_rdy,   64'h1);
    check_eq("wrap_wr_wen",  mem_wen,   64'h1);
    check_eq("wrap_wr_addr", mem_addr,  64'h3F);
    check_eq("wrap_wr_data", mem_wdata, D_W);
    step();
    clear_req();
    check_eq("wrap_rd_oen", mem_oen, 64'h1);
    step();
    step();
    check_eq("wrap_rsp_val",  rsp_val,  64'h1);
    check_eq("wrap_rsp_data", rsp_data, D_W);

    // ---------------- idle gap: strobes low, address held ----------------
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("idle_wen_%0d", k),  mem_wen,  64'h0);
      check_eq($sformatf("idle_oen_%0d", k),  mem_oen,  64'h0);
      check_eq($sformatf("idle_addr_%0d", k), mem_addr, 64'h3F);
      check_eq($sformatf("idle_rdy_%0d", k),  req_rdy,  64'h0);
      step();
    end

    // ---------------- reset in flight discards the read ----------------
    set_req(1, 1'b0, 6'd2, 64'h0);
    #1;
    check_eq("rst_rd_rdy", req_rdy, 64'h2);
    step();
    clear_req();
    check_eq("rst_rd_oen", mem_oen, 64'h1);
    req_val = 2'b01;
    rst     = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    clear_req();
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_t2_rsp", rsp_val, 64'h0);
    step();
    check_eq("rst_t3_rsp",      rsp_val,  64'h0);
    check_eq("rst_t3_rsp_data", rsp_data, 64'h0);
    step();
    check_eq("rst_t4_rsp", rsp_val, 64'h0);
    req_val = 2'b11;
    #1;
    check_eq("rst_ptr_tie", req_rdy, 64'h1);
    clear_req();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
